// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day controller: mode encoding,
// field widths and limits, and a constant-foldable ceil(log2) helper.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_SET_H = 2'd1,
      MODE_SET_M = 2'd2
   } mode_e;

   localparam int HH_W = 5;
   localparam int MS_W = 6;

   localparam logic [HH_W-1:0] HH_MAX = 5'd23;
   localparam logic [MS_W-1:0] MS_MAX = 6'd59;

   function automatic int clog2(input int unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (((v - 1) >> i) != 0) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Button/load inputs and time/display outputs of clock_ctrl, bundled so
// the controller and its environment share a single connection.
interface clock_ctrl_if;
   import clock_pkg::*;

   logic            btn_mode;
   logic            btn_inc;
   logic            load;
   logic [HH_W-1:0] load_hh;
   logic [MS_W-1:0] load_mm;
   logic [MS_W-1:0] load_ss;
   logic [HH_W-1:0] hh;
   logic [MS_W-1:0] mm;
   logic [MS_W-1:0] ss;
   logic [1:0]      mode;
   logic            blink;
   logic            sec_tick;
   logic            load_err;

   modport master (
      output btn_mode, btn_inc, load, load_hh, load_mm, load_ss,
      input  hh, mm, ss, mode, blink, sec_tick, load_err
   );

   modport slave (
      input  btn_mode, btn_inc, load, load_hh, load_mm, load_ss,
      output hh, mm, ss, mode, blink, sec_tick, load_err
   );

endinterface

// File: rtl/clock_ctrl_tick_gen.sv
// Free-running 0..CLK_HZ-1 prescaler with synchronous clear. Exports the
// next count so the parent can register blink aligned with the counter.
import clock_pkg::*;

module tick_gen #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   output logic                      tick,
   output logic [clog2(CLK_HZ)-1:0]  cnt_nxt
);

   localparam int PW = clog2(CLK_HZ);
   localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] cnt_q;

   always_comb begin
      tick = (cnt_q == LAST);
      if (clr || tick) cnt_nxt = '0;
      else             cnt_nxt = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_nxt;
   end

endmodule

// File: rtl/clock_ctrl.sv
// HH:MM:SS time-of-day controller with run/set modes and an external load.
//   state      | meaning
//   MODE_RUN   | time advances once per prescaler wrap, sec_tick pulses
//   MODE_SET_H | counting halted, btn_inc steps hours, blink active
//   MODE_SET_M | counting halted, btn_inc steps minutes (no carry), blink active
import clock_pkg::*;

module clock_ctrl #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   clock_ctrl_if.slave bus
);

   localparam int PW = clog2(CLK_HZ);
   localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

   mode_e           mode_q, mode_d;
   logic [HH_W-1:0] hh_q, hh_d;
   logic [MS_W-1:0] mm_q, mm_d;
   logic [MS_W-1:0] ss_q, ss_d;
   logic            sec_tick_q, sec_tick_d;
   logic            load_err_q, load_err_d;
   logic            blink_q, blink_d;
   logic            cnt_clr;
   logic            tick;
   logic [PW-1:0]   cnt_nxt;
   logic            load_ok;

   tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .tick    (tick),
      .cnt_nxt (cnt_nxt)
   );

   assign load_ok = (bus.load_hh <= HH_MAX) && (bus.load_mm <= MS_MAX) &&
                    (bus.load_ss <= MS_MAX);

   // Event priority: load > btn_mode > btn_inc > tick; losers are dropped.
   // A rejected load still wins the cycle, so nothing else moves with it.
   always_comb begin
      mode_d     = mode_q;
      hh_d       = hh_q;
      mm_d       = mm_q;
      ss_d       = ss_q;
      sec_tick_d = 1'b0;
      load_err_d = 1'b0;
      cnt_clr    = 1'b0;

      if (bus.load) begin
         if (load_ok) begin
            hh_d    = bus.load_hh;
            mm_d    = bus.load_mm;
            ss_d    = bus.load_ss;
            mode_d  = MODE_RUN;
            cnt_clr = 1'b1;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (bus.btn_mode) begin
         case (mode_q)
            MODE_RUN: begin
               mode_d = MODE_SET_H;
               ss_d   = '0;
            end
            MODE_SET_H: mode_d = MODE_SET_M;
            default: begin
               mode_d  = MODE_RUN;
               cnt_clr = 1'b1;
            end
         endcase
      end else if (bus.btn_inc && (mode_q != MODE_RUN)) begin
         if (mode_q == MODE_SET_H) hh_d = (hh_q == HH_MAX) ? '0 : hh_q + 1'b1;
         else                      mm_d = (mm_q == MS_MAX) ? '0 : mm_q + 1'b1;
      end else if (tick && (mode_q == MODE_RUN)) begin
         sec_tick_d = 1'b1;
         if (ss_q == MS_MAX) begin
            ss_d = '0;
            if (mm_q == MS_MAX) begin
               mm_d = '0;
               hh_d = (hh_q == HH_MAX) ? '0 : hh_q + 1'b1;
            end else begin
               mm_d = mm_q + 1'b1;
            end
         end else begin
            ss_d = ss_q + 1'b1;
         end
      end

      blink_d = (mode_d != MODE_RUN) && (cnt_nxt < HALF);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q     <= MODE_RUN;
         hh_q       <= '0;
         mm_q       <= '0;
         ss_q       <= '0;
         sec_tick_q <= 1'b0;
         load_err_q <= 1'b0;
         blink_q    <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         hh_q       <= hh_d;
         mm_q       <= mm_d;
         ss_q       <= ss_d;
         sec_tick_q <= sec_tick_d;
         load_err_q <= load_err_d;
         blink_q    <= blink_d;
      end
   end

   assign bus.hh       = hh_q;
   assign bus.mm       = mm_q;
   assign bus.ss       = ss_q;
   assign bus.mode     = mode_q;
   assign bus.blink    = blink_q;
   assign bus.sec_tick = sec_tick_q;
   assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl at CLK_HZ=4: directed scenarios plus random button/load
// traffic, checked every cycle against a seconds-of-day reference model.
module tb_clock_ctrl;

   localparam int HZ = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   clock_ctrl_if bus();

   clock_ctrl #(.CLK_HZ(HZ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   int m_hh = 0, m_mm = 0, m_ss = 0, m_mode = 0, m_cnt = 0;
   int e_st = 0, e_le = 0, e_bl = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time kept as seconds-of-day, prescaler as a modulo phase.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_hh <= 0; m_mm <= 0; m_ss <= 0; m_mode <= 0; m_cnt <= 0;
         e_st <= 0; e_le <= 0; e_bl <= 0;
      end else begin
         automatic int tod   = m_hh * 3600 + m_mm * 60 + m_ss;
         automatic int h     = m_hh;
         automatic int m     = m_mm;
         automatic int s     = m_ss;
         automatic int md    = m_mode;
         automatic int ncnt  = (m_cnt + 1) % HZ;
         automatic int st    = 0;
         automatic int le    = 0;
         automatic bit fired = (m_cnt == HZ - 1);
         if (bus.load) begin
            if (bus.load_hh < 24 && bus.load_mm < 60 && bus.load_ss < 60) begin
               h = bus.load_hh; m = bus.load_mm; s = bus.load_ss;
               md = 0; ncnt = 0;
            end else begin
               le = 1;
            end
         end else if (bus.btn_mode) begin
            if (md == 0)      begin md = 1; s = 0; end
            else if (md == 1) md = 2;
            else              begin md = 0; ncnt = 0; end
         end else if (bus.btn_inc && md != 0) begin
            if (md == 1) h = (h + 1) % 24;
            else         m = (m + 1) % 60;
         end else if (fired && md == 0) begin
            tod = (tod + 1) % 86400;
            h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
            st = 1;
         end
         m_hh <= h; m_mm <= m; m_ss <= s; m_mode <= md; m_cnt <= ncnt;
         e_st <= st; e_le <= le;
         e_bl <= (md != 0 && ncnt < HZ / 2) ? 1 : 0;
      end
   end

   always @(negedge clk) begin
      check("hh", int'(bus.hh), m_hh);
      check("mm", int'(bus.mm), m_mm);
      check("ss", int'(bus.ss), m_ss);
      check("mode", int'(bus.mode), m_mode);
      check("sec_tick", int'(bus.sec_tick), e_st);
      check("load_err", int'(bus.load_err), e_le);
      check("blink", int'(bus.blink), e_bl);
   end

   task automatic step(input bit bm, input bit bi, input bit ld,
                       input int lh, input int lm, input int ls);
      bus.btn_mode = bm;
      bus.btn_inc  = bi;
      bus.load     = ld;
      bus.load_hh  = 5'(lh);
      bus.load_mm  = 6'(lm);
      bus.load_ss  = 6'(ls);
      @(negedge clk);
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.load     = 1'b0;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int blink_exp [8];
      blink_exp = '{0, 1, 1, 0, 0, 1, 1, 0};
      bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.load = 1'b0;
      bus.load_hh = '0; bus.load_mm = '0; bus.load_ss = '0;

      repeat (2) @(negedge clk);
      check("rst_hh", int'(bus.hh), 0);
      check("rst_mode", int'(bus.mode), 0);
      rst = 1'b1;

      // 1: first seconds after release
      for (int i = 1; i <= 8; i++) begin
         idle();
         if (i == 4) begin
            check("t1_ss_at4", int'(bus.ss), 1);
            check("t1_tick_at4", int'(bus.sec_tick), 1);
         end
         if (i == 8) begin
            check("t1_ss_at8", int'(bus.ss), 2);
            check("t1_tick_at8", int'(bus.sec_tick), 1);
         end
      end
      check("t1_mode", int'(bus.mode), 0);

      // 2: load and midnight wrap
      step(0, 0, 1, 23, 59, 58);
      check("t2_load_ss", int'(bus.ss), 58);
      repeat (4) idle();
      check("t2_ss59", int'(bus.ss), 59);
      check("t2_tick1", int'(bus.sec_tick), 1);
      repeat (4) idle();
      check("t2_wrap_hh", int'(bus.hh), 0);
      check("t2_wrap_mm", int'(bus.mm), 0);
      check("t2_wrap_ss", int'(bus.ss), 0);
      check("t2_tick2", int'(bus.sec_tick), 1);

      // 3: set hours, blink phase
      step(1, 0, 0, 0, 0, 0);
      check("t3_mode", int'(bus.mode), 1);
      check("t3_ss", int'(bus.ss), 0);
      repeat (25) step(0, 1, 0, 0, 0, 0);
      check("t3_hh", int'(bus.hh), 1);
      for (int i = 0; i < 8; i++) begin
         idle();
         check("t3_blink", int'(bus.blink), blink_exp[i]);
         check("t3_no_tick", int'(bus.sec_tick), 0);
      end

      // 4: minute wrap in SET_M, full second after return to RUN
      step(0, 0, 1, 5, 59, 30);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("t4_mode", int'(bus.mode), 2);
      step(0, 1, 0, 0, 0, 0);
      check("t4_mm", int'(bus.mm), 0);
      check("t4_hh", int'(bus.hh), 5);
      step(1, 0, 0, 0, 0, 0);
      check("t4_run", int'(bus.mode), 0);
      repeat (3) idle();
      check("t4_ss_hold", int'(bus.ss), 0);
      idle();
      check("t4_ss_inc", int'(bus.ss), 1);
      check("t4_tick", int'(bus.sec_tick), 1);

      // 5: rejected load, then load beats buttons
      step(0, 0, 1, 10, 60, 10);
      check("t5_err", int'(bus.load_err), 1);
      check("t5_hh", int'(bus.hh), 5);
      check("t5_mm", int'(bus.mm), 0);
      check("t5_ss", int'(bus.ss), 1);
      idle();
      check("t5_err_clr", int'(bus.load_err), 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 12, 34, 56);
      check("t5_mode", int'(bus.mode), 0);
      check("t5_hh_ld", int'(bus.hh), 12);
      check("t5_ss_ld", int'(bus.ss), 56);

      // 6: asynchronous reset between edges, in RUN and in SET_M
      repeat (2) idle();
      #2 rst = 1'b0;
      #1;
      check("t6_run_hh", int'(bus.hh), 0);
      check("t6_run_ss", int'(bus.ss), 0);
      @(negedge clk);
      rst = 1'b1;
      step(0, 0, 1, 7, 8, 9);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("t6_setm", int'(bus.mode), 2);
      idle();
      #3 rst = 1'b0;
      #1;
      check("t6_set_mode", int'(bus.mode), 0);
      check("t6_set_hh", int'(bus.hh), 0);
      check("t6_set_mm", int'(bus.mm), 0);
      check("t6_set_blink", int'(bus.blink), 0);
      @(negedge clk);
      rst = 1'b1;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0, int'($urandom_range(0, 27)),
              int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Time-of-day controller for the clock subsystem. Owns the shared 1 Hz prescaler and sequences the HH:MM:SS counters through run and set modes. Accepts single-cycle, already-debounced button pulses and an external load port. Drives display digits, the set-mode blink enable and a seconds strobe for downstream consumers.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; prescaler period in cycles (>=2).
PW, derived localparam = ceil(log2(CLK_HZ)), prescaler counter width (not overridable).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = reset).
btn_mode  in  1  1-cycle pulse; advance mode.
btn_inc  in  1  1-cycle pulse; increment the field being set.
load  in  1  1-cycle pulse; load time from load_hh/mm/ss.
load_hh  in  5  hours to load, 0..23.
load_mm  in  6  minutes to load, 0..59.
load_ss  in  6  seconds to load, 0..59.
hh  out  5  hours, 0..23.
mm  out  6  minutes, 0..59.
ss  out  6  seconds, 0..59.
mode  out  2  0=RUN, 1=SET_H, 2=SET_M (3 never driven).
blink  out  1  display blink enable for the field being set.
sec_tick  out  1  1-cycle pulse on each seconds increment.
load_err  out  1  1-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst=0, async): hh=mm=ss=0, mode=RUN, prescaler cnt=0, blink=0, sec_tick=0, load_err=0. All outputs are registered.
- Prescaler: cnt counts 0..CLK_HZ-1 and wraps, running in every mode. Internal tick=1 when cnt==CLK_HZ-1.
- First ss increment after reset release occurs on the CLK_HZ-th rising edge.
- RUN, tick=1:
  - ss+1. ss 59->0 carries into mm; mm 59->0 carries into hh; hh 23->0.
  - sec_tick=1 on the same edge the time outputs update; otherwise sec_tick=0.
- Mode FSM, on btn_mode: RUN->SET_H->SET_M->RUN.
  - RUN->SET_H: ss cleared to 0, counting halts.
  - SET_M->RUN: cnt cleared to 0, so the first second after leaving set is a full CLK_HZ cycles.
- btn_inc:
  - SET_H: hh=(hh+1) mod 24.
  - SET_M: mm=(mm+1) mod 60, no carry into hh.
  - RUN: ignored.
- blink: in SET_H/SET_M, blink=1 while cnt < CLK_HZ/2 (integer division), else 0. blink=0 in RUN.
- sec_tick is never asserted outside RUN.
- load:
  - Accepted when load_hh<=23, load_mm<=59 and load_ss<=59. On acceptance: time <= load values, mode=RUN, cnt=0, no sec_tick that cycle.
  - Otherwise the load is rejected: load_err=1 for one cycle and all other state is unchanged.
- Priority in one cycle (highest first): load > btn_mode > btn_inc > tick.
  - A lower-priority event coinciding with a higher one is dropped, not deferred.
  - Example: btn_mode with tick in RUN enters SET_H with ss=0 and no sec_tick.
- Reset asserted mid-operation: all state returns to reset values immediately. No pending events survive.
- Widths: all increments use explicit compare-and-wrap; hh/mm/ss never take out-of-range values.

Decomposition:
- Shared package clock_pkg: mode encoding constants (MODE_RUN=2'd0, MODE_SET_H=2'd1, MODE_SET_M=2'd2), HH_MAX=23, MS_MAX=59, field widths (HH_W=5, MS_W=6), and the ceil-log2 function.
- One sub-module, tick_gen: the prescaler, with an added synchronous clear input and an exported count for the blink compare.
- Time counters and FSM stay in clock_ctrl.

Test Plan:
(bench uses CLK_HZ=4)
1. Reset release, run 8 cycles -> ss=1 at the 4th edge, ss=2 at the 8th; sec_tick high exactly those two cycles; mode=0.
2. load 23:59:58, wait 8 cycles -> 23:59:59, then 00:00:00 with hh/mm/ss all wrapping on the same edge; sec_tick on both.
3. btn_mode -> mode=1, ss=0. btn_inc x25 -> hh advances 25 mod 24 (0->1 from 00:xx). blink pattern 1,1,0,0 repeating. No sec_tick.
4. btn_mode to SET_M at mm=59, btn_inc -> mm=0, hh unchanged. btn_mode -> RUN, cnt=0, next ss increment exactly 4 cycles later.
5. load with load_mm=60 -> load_err pulse for one cycle, time and mode unchanged. load with btn_mode and btn_inc in the same cycle -> load wins, mode=RUN.
6. Assert rst low mid-count and mid-SET_M, asynchronously between edges -> outputs go to zero/RUN immediately, without waiting for a clock edge.
